// File: rtl/baud_rate_gen.sv
// ----------------------------------------------------------------------------
// baud_rate_gen
//
// Fractional baud-rate generator for a UART. A down-counter counts off the
// integer part of the divisor. A fractional accumulator adds one extra cycle
// whenever its sum wraps, so the average tick period becomes
// shadow_val + 1 + shadow_frac / 2^FRAC_W. A second counter divides the
// oversample ticks down to the bit rate.
//
// Parameters
//   CNT_W  : integer divider width (4..24)
//   FRAC_W : fractional divider width (1..8)
//   OVS    : oversample ticks per bit (4..32)
//
// Ports
//   clk        : system clock, rising edge
//   reset_n    : synchronous active-low reset
//   enable     : divider runs when 1 and holds when 0
//   load       : captures baud_val / baud_frac into the shadow registers
//   baud_val   : integer divisor minus one
//   baud_frac  : fractional divisor in units of 1/2^FRAC_W
//   rx_sync    : one-cycle pulse that restarts bit timing
//   baud_tick  : registered oversample tick, one cycle wide
//   xmit_pulse : registered bit-rate pulse, only ever high together with baud_tick
//   os_phase   : current oversample index, 0..OVS-1
// ----------------------------------------------------------------------------
module baud_rate_gen #(
    parameter int  CNT_W  = 16,
    parameter int  FRAC_W = 4,
    parameter int  OVS    = 16,
    localparam int OVS_W  = $clog2(OVS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              load,
    input  logic [CNT_W-1:0]  baud_val,
    input  logic [FRAC_W-1:0] baud_frac,
    input  logic              rx_sync,
    output logic              baud_tick,
    output logic              xmit_pulse,
    output logic [OVS_W-1:0]  os_phase
);

    localparam logic [OVS_W-1:0] OS_LAST = OVS_W'(OVS - 1);
    localparam logic [OVS_W-1:0] OS_ONE  = OVS_W'(1);
    localparam logic [CNT_W:0]   CNT_ZERO = {(CNT_W+1){1'b0}};
    localparam logic [CNT_W:0]   CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};

    logic [CNT_W-1:0]  shadow_val_r;
    logic [FRAC_W-1:0] shadow_frac_r;
    // One bit wider than the divisor so all-ones plus a carry still fits.
    logic [CNT_W:0]    cntr_r;
    logic [FRAC_W-1:0] acc_r;
    logic [OVS_W-1:0]  os_cntr_r;
    logic              baud_tick_r;
    logic              xmit_pulse_r;

    logic [FRAC_W:0]   frac_sum_s;
    logic [CNT_W:0]    reload_s;
    logic [CNT_W:0]    sync_val_s;
    logic              os_wrap_s;
    logic [OVS_W-1:0]  os_next_s;
    logic              cnt_zero_s;

    // Next-value arithmetic for the tick event and the rx_sync restart.
    always_comb begin
        frac_sum_s = {1'b0, acc_r} + {1'b0, shadow_frac_r};
        // Top bit of the fractional sum is the carry that stretches the next period.
        reload_s   = {1'b0, shadow_val_r} + {{CNT_W{1'b0}}, frac_sum_s[FRAC_W]};
        cnt_zero_s = (cntr_r == CNT_ZERO);
        os_wrap_s  = (os_cntr_r == OS_LAST);
        // A load on the same edge as rx_sync must take effect immediately.
        if (load) begin
            sync_val_s = {1'b0, baud_val};
        end else begin
            sync_val_s = {1'b0, shadow_val_r};
        end
        if (os_wrap_s) begin
            os_next_s = {OVS_W{1'b0}};
        end else begin
            os_next_s = os_cntr_r + OS_ONE;
        end
    end

    // Shadow registers, divider state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_val_r  <= {CNT_W{1'b0}};
            shadow_frac_r <= {FRAC_W{1'b0}};
            cntr_r        <= CNT_ZERO;
            acc_r         <= {FRAC_W{1'b0}};
            os_cntr_r     <= {OVS_W{1'b0}};
            baud_tick_r   <= 1'b0;
            xmit_pulse_r  <= 1'b0;
        end else begin
            // Shadow values are only consumed at the next reload, so the
            // period already in progress finishes with the old divisor.
            if (load) begin
                shadow_val_r  <= baud_val;
                shadow_frac_r <= baud_frac;
            end

            if (rx_sync) begin
                cntr_r       <= sync_val_s;
                acc_r        <= {FRAC_W{1'b0}};
                os_cntr_r    <= {OVS_W{1'b0}};
                baud_tick_r  <= 1'b0;
                xmit_pulse_r <= 1'b0;
            end else if (enable) begin
                if (cnt_zero_s) begin
                    acc_r        <= frac_sum_s[FRAC_W-1:0];
                    cntr_r       <= reload_s;
                    os_cntr_r    <= os_next_s;
                    baud_tick_r  <= 1'b1;
                    xmit_pulse_r <= os_wrap_s;
                end else begin
                    cntr_r       <= cntr_r - CNT_ONE;
                    baud_tick_r  <= 1'b0;
                    xmit_pulse_r <= 1'b0;
                end
            end else begin
                baud_tick_r  <= 1'b0;
                xmit_pulse_r <= 1'b0;
            end
        end
    end

    assign baud_tick  = baud_tick_r;
    assign xmit_pulse = xmit_pulse_r;
    assign os_phase   = os_cntr_r;

endmodule

// File: tb/tb_baud_rate_gen.sv
// ----------------------------------------------------------------------------
// tb_baud_rate_gen
//
// Scoreboard bench for baud_rate_gen (CNT_W=8, FRAC_W=4, OVS=16). Each
// scenario pushes the expected tick spacing, xmit_pulse and os_phase of every
// upcoming tick into a queue. The monitor loop pops one entry per observed
// tick and compares it with the DUT.
// ----------------------------------------------------------------------------
module tb_baud_rate_gen;

    localparam int CW = 8;
    localparam int FW = 4;
    localparam int NOVS = 16;
    localparam int FR = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          load;
    logic [CW-1:0] baud_val;
    logic [FW-1:0] baud_frac;
    logic          rx_sync;
    logic          baud_tick;
    logic          xmit_pulse;
    logic [3:0]    os_phase;

    typedef struct {
        int   gap;
        logic xmit;
        int   phase;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad = 0;
    int   ecnt = 0;
    int   ref_edge = 0;
    int   last_ev = 0;
    int   pend_cycles = 0;

    baud_rate_gen #(.CNT_W(CW), .FRAC_W(FW), .OVS(NOVS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load       (load),
        .baud_val   (baud_val),
        .baud_frac  (baud_frac),
        .rx_sync    (rx_sync),
        .baud_tick  (baud_tick),
        .xmit_pulse (xmit_pulse),
        .os_phase   (os_phase)
    );

    always #5 clk = ~clk;

    // Count rising edges so spacing can be measured in edges.
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, want, ecnt);
        end
    endtask

    // Expected ticks for a run of n ticks, acc starting at 0.
    // Spacing of tick i is val+1 plus the carry produced by tick i-1, i.e.
    // floor(i*frac/16) - floor((i-1)*frac/16).
    task automatic push_run(input int n, input int val, input int frac,
                            input int start_phase, input int extra_idx, input int extra);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.gap = val + 1;
            if (i > 0) e.gap += (i * frac) / FR - ((i - 1) * frac) / FR;
            if (i == extra_idx) e.gap += extra;
            e.phase = (start_phase + i + 1) % NOVS;
            e.xmit  = (e.phase == 0);
            pend_cycles += e.gap;
            exp_q.push_back(e);
        end
    endtask

    // rx_sync (with a simultaneous load) that restarts timing.
    task automatic do_sync(input int val, input int frac);
        @(negedge clk);
        rx_sync = 1'b1;
        load = 1'b1;
        baud_val = CW'(val);
        baud_frac = FW'(frac);
        @(negedge clk);
        chk("sync_tick", baud_tick, 0);
        chk("sync_xmit", xmit_pulse, 0);
        chk("sync_phase", os_phase, 0);
        rx_sync = 1'b0;
        load = 1'b0;
        ref_edge = ecnt;
        last_ev = ecnt;
    endtask

    // Monitor/driver loop: pops the expected entry on every observed tick.
    task automatic score(input int stall_rel, input int load_rel, input int load_val,
                         input int glitch_rel);
        int   rel;
        int   frozen;
        exp_t e;
        int   budget;
        budget = pend_cycles + 20;
        frozen = 0;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            @(negedge clk);
            rel = ecnt - ref_edge;
            chk("xmit_wo_tick", {31'd0, xmit_pulse & ~baud_tick}, 0);
            if (enable == 1'b0) begin
                chk("stall_tick", baud_tick, 0);
                chk("stall_phase", os_phase, frozen);
            end
            if (baud_tick === 1'b1) begin
                e = exp_q.pop_front();
                chk("gap", ecnt - last_ev, e.gap);
                chk("xmit", xmit_pulse, e.xmit);
                chk("phase", os_phase, e.phase);
                last_ev = ecnt;
            end
            load = 1'b0;
            if (rel == load_rel) begin
                load = 1'b1;
                baud_val = CW'(load_val);
            end
            if (rel == stall_rel) begin
                enable = 1'b0;
                frozen = os_phase;
            end
            if (rel == stall_rel + 7) enable = 1'b1;
            if (rel == glitch_rel) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
        end
        chk("timeout_left", exp_q.size(), 0);
        exp_q.delete();
        pend_cycles = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b0;
        load = 1'b0;
        rx_sync = 1'b0;
        baud_val = '0;
        baud_frac = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tick", baud_tick, 0);
        chk("rst_xmit", xmit_pulse, 0);
        chk("rst_phase", os_phase, 0);
        reset_n = 1'b1;
        enable = 1'b1;

        // Integer divide: val=3 -> every 4 edges, xmit on every 16th tick.
        do_sync(3, 0);
        push_run(33, 3, 0, 0, -1, 0);
        score(-100, -100, 0, -100);

        // Fractional divide: val=3, frac=8 -> 4,5,4,5...
        do_sync(3, 8);
        push_run(17, 3, 8, 0, -1, 0);
        score(-100, -100, 0, -100);

        // Enable stall of 7 edges in the third period.
        do_sync(3, 0);
        push_run(6, 3, 0, 0, 2, 7);
        score(10, -100, 0, -100);

        // Mid-period load of val=9: current spacing stays 4, then 10.
        do_sync(3, 0);
        push_run(3, 3, 0, 0, -1, 0);
        push_run(3, 9, 0, 3, -1, 0);
        score(-100, 10, 9, -100);

        // rx_sync with val=5, plus a reset glitch between edges.
        do_sync(5, 0);
        push_run(17, 5, 0, 0, -1, 0);
        score(-100, -100, 0, 20);

        // All-ones divisor plus a carry: 256+1 edges, no overflow.
        do_sync(255, 15);
        push_run(3, 255, 15, 0, -1, 0);
        score(-100, -100, 0, -100);

        // One-edge reset mid-run beats load and rx_sync; shadow returns to 0.
        @(negedge clk);
        reset_n = 1'b0;
        load = 1'b1;
        rx_sync = 1'b1;
        baud_val = 8'd7;
        baud_frac = 4'd5;
        @(negedge clk);
        chk("rst2_tick", baud_tick, 0);
        chk("rst2_xmit", xmit_pulse, 0);
        chk("rst2_phase", os_phase, 0);
        reset_n = 1'b1;
        load = 1'b0;
        rx_sync = 1'b0;
        ref_edge = ecnt;
        last_ev = ecnt;
        push_run(20, 0, 0, 0, -1, 0);
        score(-100, -100, 0, -100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
